chunked_rca_adder: RTL and testbench

// Multi-cycle, parametrised ripple-carry add/subtract unit. Splits an NBIT operation into NBIT/CHUNK

---
 rtl/chunked_rca_adder.sv | 120 ++++++++++++
 tb/tb_chunked_rca_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_rca_adder.sv
// Multi-cycle add/subtract: ripples one CHUNK-bit slice per clock, LSB first, result NBIT/CHUNK cycles after accept.
// Holds the result in DONE until out_ready; in_ready is high only while IDLE.
module chunked_rca_adder #(
  parameter int NBIT  = 8,
  parameter int CHUNK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] s,
  output logic            cout,
  output logic            ovf
);

  localparam int NSTEP = NBIT / CHUNK;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NBIT-1:0] op_a;
  logic [NBIT-1:0] op_b;
  logic            carry;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK+1:0] rc;       // {carry out of MSB, carry into MSB, slice sum}
  logic [NBIT-1:0]  sum_ext;
  logic             last;
  int               shamt;

  // Bit-level ripple chain for one slice; local variables keep the chain out of the netlist loop check.
  function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c_in);
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] sm;
    c    = '0;
    sm   = '0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      sm[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    return {c[CHUNK], c[CHUNK-1], sm};
  endfunction

  always_comb begin
    shamt   = CHUNK * int'(cnt);
    slice_a = CHUNK'(op_a >> shamt);
    slice_b = CHUNK'(op_b >> shamt);
    rc      = ripple(slice_a, slice_b, carry);
    sum_ext = NBIT'(rc[CHUNK-1:0]) << shamt;
    last    = (cnt == CW'(NSTEP - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            s        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Slices are disjoint and s was cleared on accept, so OR-in writes just this slice.
          s     <= s | sum_ext;
          carry <= rc[CHUNK+1];
          if (last) begin
            cout      <= rc[CHUNK+1];
            ovf       <= rc[CHUNK+1] ^ rc[CHUNK];
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_rca_adder.sv
// Scoreboard bench: four adders (CHUNK 1,2,4,8) at NBIT=8 against an integer-arithmetic reference.
module tb_chunked_rca_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [7:0] a         [4];
  logic [7:0] b         [4];
  logic       cin       [4];
  logic       sub       [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] s         [4];
  logic       cout      [4];
  logic       ovf       [4];

  logic [9:0] exp_q [4][$];   // {cout, ovf, s}
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic sb);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int c  = ci;
    int r;
    int sr;
    logic co;
    logic ov;
    if (sb) begin
      r  = ux - uy - c;
      sr = sx - sy - c;
      co = (r >= 0);
    end else begin
      r  = ux + uy + c;
      sr = sx + sy + c;
      co = (r > 255);
    end
    ov = (sr > 127) || (sr < -128);
    return {co, ov, r[7:0]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : lane
    logic [9:0] e;

    chunked_rca_adder #(.NBIT(8), .CHUNK(1 << g)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a[g]), .b(b[g]), .cin(cin[g]), .sub(sub[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .s(s[g]), .cout(cout[g]), .ovf(ovf[g])
    );

    always @(negedge clk) begin
      if (!rst && out_valid[g] && out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          $display("FAIL lane%0d unexpected result: got 0x%0h, expected no output", g, s[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("lane%0d result {cout,ovf,s}", g), int'({cout[g], ovf[g], s[g]}), int'(e));
        end
      end
    end
  end

  task automatic issue(input int l, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic sb, input logic [9:0] ex, input bit push);
    int n = 0;
    while (!in_ready[l] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready[l]) begin
      checks++;
      $display("FAIL lane%0d in_ready timeout: got 0, expected 1", l);
    end
    in_valid[l] = 1'b1;
    a[l] = x; b[l] = y; cin[l] = ci; sub[l] = sb;
    if (push) exp_q[l].push_back(ex);
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
    a[l] = $urandom; b[l] = $urandom; cin[l] = $urandom; sub[l] = $urandom;
  endtask

  task automatic wait_valid(input int l, output int n);
    n = 0;
    while (!out_valid[l] && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] x, y;
    logic ci, sb;

    rst = 1'b1;
    for (int l = 0; l < 4; l++) begin
      in_valid[l] = 1'b0; a[l] = '0; b[l] = '0; cin[l] = 1'b0; sub[l] = 1'b0;
      out_ready[l] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int l = 0; l < 4; l++) begin
      check($sformatf("lane%0d reset in_ready", l), int'(in_ready[l]), 1);
      check($sformatf("lane%0d reset out_valid", l), int'(out_valid[l]), 0);
      check($sformatf("lane%0d reset s", l), int'(s[l]), 0);
    end

    // Known vectors on CHUNK=2 (lane 1): four slice cycles each.
    issue(1, 8'h5A, 8'h3C, 1'b0, 1'b0, {1'b0, 1'b1, 8'h96}, 1'b1);
    wait_valid(1, n); check("add 5A+3C latency", n, 4);
    @(posedge clk); #1;
    issue(1, 8'hFF, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00}, 1'b1);
    wait_valid(1, n); check("add FF+00+1 latency", n, 4);
    @(posedge clk); #1;
    issue(1, 8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0}, 1'b1);
    wait_valid(1, n); check("sub 10-20 latency", n, 4);
    @(posedge clk); #1;
    issue(1, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, 1'b1);
    wait_valid(1, n); check("sub 80-01 latency", n, 4);
    @(posedge clk); #1;

    // Back-pressure with a competing in_valid held through RUN and DONE.
    out_ready[1] = 1'b0;
    issue(1, 8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 1'b0, 8'h46}, 1'b1);
    in_valid[1] = 1'b1; a[1] = 8'hAA; b[1] = 8'h55; cin[1] = 1'b1; sub[1] = 1'b1;
    wait_valid(1, n); check("stall latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      check("stall out_valid", int'(out_valid[1]), 1);
      check("stall in_ready", int'(in_ready[1]), 0);
      check("stall s", int'(s[1]), 8'h46);
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("post-stall out_valid", int'(out_valid[1]), 0);
      check("post-stall in_ready", int'(in_ready[1]), 1);
      @(posedge clk); #1;
    end

    // Reset during the second RUN cycle drops the operation.
    issue(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 10'h0, 1'b0);
    @(posedge clk); #1;
    check("partial s after slice 0", int'(s[1]), 8'h02);
    check("partial out_valid", int'(out_valid[1]), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-run reset in_ready", int'(in_ready[1]), 1);
    check("mid-run reset out_valid", int'(out_valid[1]), 0);
    check("mid-run reset s", int'(s[1]), 0);
    issue(1, 8'h33, 8'h44, 1'b1, 1'b0, {1'b0, 1'b0, 8'h78}, 1'b1);
    wait_valid(1, n); check("after reset latency", n, 4);
    @(posedge clk); #1;

    // Random sweep over every chunk width with random output stalls.
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 30; k++) begin
        x = $urandom; y = $urandom; ci = $urandom; sb = $urandom;
        if (k % 7 == 0) x = 8'hFF;
        if (k % 9 == 0) y = 8'h80;
        out_ready[l] = ($urandom_range(0, 2) == 0);
        issue(l, x, y, ci, sb, model(x, y, ci, sb), 1'b1);
        wait_valid(l, n);
        check($sformatf("lane%0d random latency", l), n, 8 >> l);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        out_ready[l] = 1'b1;
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    for (int l = 0; l < 4; l++)
      check($sformatf("lane%0d scoreboard drained", l), exp_q[l].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
